// File: rtl/sha256_pkg.sv
// Shared SHA-256 definitions: word/window sizes, schedule FSM states and
// the output-register payload layout.
package sha256_pkg;

    localparam int unsigned WORD_W      = 32;
    localparam int unsigned SCHED_DEPTH = 16;
    localparam int unsigned T_W         = 7;
    localparam int unsigned IDX_W       = 6;

    typedef enum logic {
        LOAD   = 1'b0,
        EXPAND = 1'b1
    } sched_state_e;

    typedef struct packed {
        logic [WORD_W-1:0] word;
        logic [IDX_W-1:0]  index;
        logic              last;
    } sched_out_t;

endpackage

// File: rtl/msg_schedule_sigma.sv
// Small-sigma functions of the SHA-256 message schedule.
//   MOD_S0: y_c = ROTR7(x)  ^ ROTR18(x) ^ SHR3(x)
//   MOD_S1: y_c = ROTR17(x) ^ ROTR19(x) ^ SHR10(x)
// Ports: x (input word), y_c (combinational result).
module MOD_S0
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y_c
);
    assign y_c = {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
endmodule

module MOD_S1
    import sha256_pkg::*;
(
    input  logic [WORD_W-1:0] x,
    output logic [WORD_W-1:0] y_c
);
    assign y_c = {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
endmodule

// File: rtl/msg_schedule.sv
// SHA-256 message-schedule generator.
// Takes 16 message words over in_valid/in_ready, emits W[0..ROUNDS-1] over
// out_valid/out_ready through a single output register.
// Ports: clk, rst_n; in_valid/in_ready/in_word; out_valid/out_ready/out_word,
//        out_index (t of presented word), out_last (W[ROUNDS-1]); busy.
module msg_schedule
    import sha256_pkg::*;
#(
    parameter int unsigned ROUNDS = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [0:WORD_W-1] in_word,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [0:WORD_W-1] out_word,
    output logic [IDX_W-1:0]  out_index,
    output logic              out_last,
    output logic              busy
);

    sched_state_e      state_q, state_d;
    logic [T_W-1:0]    t_q, t_d, t_cur;
    sched_out_t        out_q, out_d;
    logic              out_valid_q, out_valid_d;
    logic              busy_q, busy_d;
    logic              alive_q;
    logic [WORD_W-1:0] win_q [SCHED_DEPTH];

    logic              wr_ok, done, in_hs, gen, push, last_hs;
    logic [WORD_W-1:0] s0_w, s1_w, exp_word, push_word;

    // Window entry 1 = W[t-15], entry 14 = W[t-2].
    MOD_S0 u_s0 (.x(win_q[1]),  .y_c(s0_w));
    MOD_S1 u_s1 (.x(win_q[14]), .y_c(s1_w));

    assign exp_word  = s1_w + win_q[9] + s0_w + win_q[0];

    assign wr_ok     = !out_valid_q || out_ready;
    assign done      = (t_q == T_W'(ROUNDS));
    // Input is also accepted while W[ROUNDS-1] drains so blocks run back to back.
    assign in_ready  = alive_q && wr_ok && ((state_q == LOAD) || done);
    assign in_hs     = in_valid && in_ready;
    assign gen       = (state_q == EXPAND) && (t_q < T_W'(ROUNDS)) && wr_ok;
    assign push      = in_hs || gen;
    assign push_word = in_hs ? WORD_W'(in_word) : exp_word;
    assign last_hs   = out_valid_q && out_ready && out_q.last;
    assign t_cur     = done ? '0 : t_q;

    // Registers: FSM state, t counter, output stage, busy, window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= LOAD;
            t_q         <= '0;
            out_q       <= '0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            alive_q     <= 1'b0;
            for (int unsigned i = 0; i < SCHED_DEPTH; i++) begin
                win_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            t_q         <= t_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
            alive_q     <= 1'b1;
            if (push) begin
                for (int unsigned i = 0; i < SCHED_DEPTH - 1; i++) begin
                    win_q[i] <= win_q[i+1];
                end
                win_q[SCHED_DEPTH-1] <= push_word;
            end
        end
    end

    // Next-state and output-register logic.
    always_comb begin
        state_d     = state_q;
        t_d         = t_q;
        out_d       = out_q;
        out_valid_d = out_valid_q;
        busy_d      = busy_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        if (last_hs) begin
            state_d = LOAD;
            t_d     = '0;
            busy_d  = 1'b0;
        end
        if (push) begin
            out_d.word  = push_word;
            out_d.index = IDX_W'(t_cur);
            out_d.last  = (t_cur == T_W'(ROUNDS - 1));
            out_valid_d = 1'b1;
            t_d         = t_cur + T_W'(1);
            if (in_hs) begin
                busy_d = 1'b1;
                if (t_cur == T_W'(SCHED_DEPTH - 1)) begin
                    state_d = EXPAND;
                end
            end
        end
    end

    assign out_valid = out_valid_q;
    assign out_word  = out_q.word;
    assign out_index = out_q.index;
    assign out_last  = out_q.last;
    assign busy      = busy_q;

endmodule

// File: tb/tb_msg_schedule.sv
// Randomized self-checking bench for msg_schedule against a plain SHA-256
// schedule model.
module tb_msg_schedule;

    localparam int unsigned ROUNDS = 64;

    typedef logic [31:0] blk_t [16];

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [0:31] in_word = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [0:31] out_word;
    logic [5:0]  out_index;
    logic        out_last;
    logic        busy;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;

    logic [31:0] in_q [$];
    logic [31:0] exp_q [$];
    logic [31:0] got_q [$];

    msg_schedule #(.ROUNDS(ROUNDS)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
        .out_valid(out_valid), .out_ready(out_ready), .out_word(out_word),
        .out_index(out_index), .out_last(out_last), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

    // Queue one block of input and its full expected schedule.
    task automatic push_block(input blk_t m);
        logic [31:0] w [ROUNDS];
        for (int t = 0; t < 16; t++) begin
            w[t] = m[t];
            in_q.push_back(m[t]);
        end
        for (int t = 16; t < int'(ROUNDS); t++) begin
            w[t] = sig1(w[t-2]) + w[t-7] + sig0(w[t-15]) + w[t-16];
        end
        for (int t = 0; t < int'(ROUNDS); t++) begin
            exp_q.push_back(w[t]);
        end
    endtask

    function automatic blk_t abc_block();
        blk_t m;
        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        m[0]  = 32'h61626380;
        m[15] = 32'h00000018;
        return m;
    endfunction

    // Drive queued input, consume and check output until both queues drain.
    task automatic run_stream(input bit bp, input bit hold_valid, input string tag);
        int in_acc = 0;
        int out_acc = 0;
        int cyc = 0;
        bit prev_stall = 0, prev_out_hs = 0, prev_in_hs = 0;
        logic [31:0] prev_word = '0;
        int prev_idx = 0;
        logic prev_last = 1'b0;
        bit ohs, ihs;
        int t;
        got_q.delete();
        while ((in_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            in_valid  = (in_q.size() > 0) && (hold_valid || $urandom_range(0, 3) != 0);
            in_word   = (in_q.size() > 0) ? in_q[0] : 32'h0;
            out_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
            #1;
            if (prev_stall) begin
                check_eq({tag, "_stall_valid"}, 32'(out_valid), 32'd1);
                check_eq({tag, "_stall_word"}, out_word, prev_word);
                check_eq({tag, "_stall_idx"}, 32'(out_index), 32'(prev_idx));
                check_eq({tag, "_stall_last"}, 32'(out_last), 32'(prev_last));
            end
            if (prev_in_hs) check_eq({tag, "_latency"}, 32'(out_valid), 32'd1);
            if (!bp && prev_out_hs && prev_idx >= 15 && prev_idx < int'(ROUNDS) - 1)
                check_eq({tag, "_no_bubble"}, 32'(out_valid), 32'd1);
            ohs = out_valid && out_ready;
            ihs = in_valid && in_ready;
            if (in_acc == 16 * (out_acc / int'(ROUNDS) + 1) && !(ohs && out_last))
                check_eq({tag, "_expand_in_ready"}, 32'(in_ready), 32'd0);
            if (ohs) begin
                t = out_acc % int'(ROUNDS);
                if (exp_q.size() == 0) begin
                    check_eq({tag, "_extra_word"}, 32'd1, 32'd0);
                end else begin
                    check_eq({tag, "_word"}, out_word, exp_q.pop_front());
                    check_eq({tag, "_index"}, 32'(out_index), 32'(t));
                    check_eq({tag, "_last"}, 32'(out_last), 32'(t == int'(ROUNDS) - 1));
                    if (t == 40) check_eq({tag, "_busy_mid"}, 32'(busy), 32'd1);
                    if (out_last && hold_valid && in_q.size() > 0)
                        check_eq({tag, "_b2b_accept"}, 32'(ihs), 32'd1);
                    got_q.push_back(out_word);
                end
                out_acc++;
            end
            if (ihs) begin
                void'(in_q.pop_front());
                in_acc++;
            end
            prev_stall  = out_valid && !out_ready;
            prev_word   = out_word;
            prev_idx    = int'(out_index);
            prev_last   = out_last;
            prev_out_hs = ohs;
            prev_in_hs  = ihs;
        end
        if (in_q.size() > 0 || exp_q.size() > 0) begin
            check_eq({tag, "_timeout"}, 32'd0, 32'd1);
            in_q.delete();
            exp_q.delete();
        end
        hs_count = out_acc;
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        check_eq({tag, "_idle_busy"}, 32'(busy), 32'd0);
        check_eq({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic check_got(input string tag, input int idx, input logic [31:0] exp);
        if (got_q.size() > idx) check_eq(tag, got_q[idx], exp);
        else check_eq({tag, "_missing"}, 32'd0, 32'd1);
    endtask

    task automatic reset_mid_expand();
        bit found = 0;
        push_block(abc_block());
        for (int c = 0; c < 500 && !found; c++) begin
            @(negedge clk);
            in_valid  = in_q.size() > 0;
            in_word   = (in_q.size() > 0) ? in_q[0] : 32'h0;
            out_ready = 1'b1;
            #1;
            if (out_valid && out_index == 6'd30) found = 1;
            else if (in_valid && in_ready) void'(in_q.pop_front());
        end
        check_eq("rst_reached_t30", 32'(found), 32'd1);
        rst_n = 1'b0;
        #1;
        check_eq("rst_mid_valid", 32'(out_valid), 32'd0);
        check_eq("rst_mid_index", 32'(out_index), 32'd0);
        check_eq("rst_mid_busy", 32'(busy), 32'd0);
        check_eq("rst_mid_in_ready", 32'(in_ready), 32'd0);
        in_q.delete();
        exp_q.delete();
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            #1;
            check_eq("rst_no_emit", 32'(out_valid), 32'd0);
        end
        push_block(abc_block());
        run_stream(1'b0, 1'b1, "post_rst");
        check_got("post_rst_w16", 16, 32'h61626380);
    endtask

    initial begin
        blk_t m;
        logic [31:0] abc_ref [$];

        repeat (3) @(negedge clk);
        #1;
        check_eq("rst_in_ready", 32'(in_ready), 32'd0);
        check_eq("rst_out_valid", 32'(out_valid), 32'd0);
        check_eq("rst_out_word", out_word, 32'h0);
        check_eq("rst_out_index", 32'(out_index), 32'd0);
        check_eq("rst_out_last", 32'(out_last), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check_eq("post_rst_in_ready", 32'(in_ready), 32'd1);

        push_block(abc_block());
        run_stream(1'b0, 1'b1, "abc");
        check_got("abc_w0", 0, 32'h61626380);
        check_got("abc_w15", 15, 32'h00000018);
        check_got("abc_w16", 16, 32'h61626380);
        check_got("abc_w17", 17, 32'h000F0000);
        check_got("abc_w18", 18, 32'h7DA86405);
        check_eq("abc_handshakes", 32'(hs_count), 32'd64);
        abc_ref = got_q;

        for (int i = 0; i < 16; i++) m[i] = 32'h0;
        push_block(m);
        run_stream(1'b0, 1'b0, "zero");
        check_got("zero_w63", 63, 32'h0);

        m[1] = 32'hFFFFFFFF;
        push_block(m);
        run_stream(1'b0, 1'b1, "ones_w1");
        check_got("ones_w16", 16, 32'h1FFFFFFF);

        push_block(abc_block());
        run_stream(1'b1, 1'b0, "abc_bp");
        for (int i = 0; i < abc_ref.size(); i++) check_got("abc_bp_same", i, abc_ref[i]);

        push_block(abc_block());
        push_block(abc_block());
        run_stream(1'b0, 1'b1, "b2b");
        check_eq("b2b_handshakes", 32'(hs_count), 32'd128);
        for (int i = 16; i < int'(ROUNDS); i++) check_got("b2b_second", i + int'(ROUNDS), abc_ref[i]);

        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) m[i] = $urandom();
            push_block(m);
        end
        run_stream(1'b1, 1'b0, "rand");

        reset_mid_expand();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
